wb_retire_buffer: RTL
=====================

WB_RETIRE_BUFFER -- requirements
Module: wb_retire_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width.
REQ-003 SHALL have port clk  input  1  the single clock; all state on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port InValid  input  1  MEM-stage result valid.
REQ-006 SHALL have port InReady  output  1  buffer can accept this cycle.
REQ-007 SHALL have port InRegWrite  input  1  instruction writes a register.
REQ-008 SHALL have port InDest  input  ADDR_W  destination register index.
REQ-009 SHALL have port InMemToReg  input  1  1 = load data, 0 = ALU result.
REQ-010 SHALL have port InAluResult  input  DATA_W  ALU result.
REQ-011 SHALL have port InMemData  input  DATA_W  raw memory word.
REQ-012 SHALL have port InLoadType  input  2  00 word, 01 byte signed, 10 byte unsigned, 11 half signed.
REQ-013 SHALL have port InByteOff  input  2  address bits [1:0] of the load.
REQ-014 SHALL have port WbHold  input  1  register-file write port unavailable this cycle.
REQ-015 SHALL have ports RegWrite / WriteRegister / WriteData  output  1 / ADDR_W / DATA_W  register-file write port.
REQ-016 SHALL have ports FwdValid / FwdReg / FwdData  output  1 / ADDR_W / DATA_W  head-entry forwarding to decode.

Function
REQ-017 SHALL hold up to 2 entries in order; states EMPTY, ONE, TWO.
REQ-018 SHALL drive InReady = 1 in EMPTY and ONE, 0 in TWO; decoded from registered state only.
REQ-019 SHALL accept an entry on a posedge where InValid && InReady; inputs ignored otherwise.
REQ-020 SHALL format data at accept: WriteData source = InMemToReg ? extended load : InAluResult; stored formatted.
REQ-021 SHALL retire the head on a posedge where state != EMPTY && !WbHold.
REQ-022 SHALL drive RegWrite = head.InRegWrite && head.InDest != 0 && state != EMPTY && !WbHold; WriteRegister/WriteData = head fields (combinational from head register).
REQ-023 SHALL retire an entry with InRegWrite=0 or InDest=0 without asserting RegWrite.
REQ-024 SHALL give latency: entry accepted at edge N drives RegWrite during cycle N..N+1, written by the register file at edge N+1 if WbHold low.
REQ-025 SHALL transition: EMPTY+accept->ONE; ONE+accept+retire->ONE (head replaced); ONE+retire->EMPTY; ONE+accept->TWO; TWO+retire->ONE; else hold.
REQ-026 SHALL sustain one accept and one retire per cycle in ONE (full throughput).
REQ-027 SHALL drive FwdValid = state != EMPTY && head.InRegWrite && head.InDest != 0; FwdReg/FwdData = head; independent of WbHold.
REQ-028 SHALL keep WriteRegister, WriteData, FwdReg, FwdData at 0 when EMPTY.

Reset
REQ-029 SHALL on rst asynchronously enter EMPTY, clear both entries to 0, RegWrite=0, FwdValid=0, InReady=1 one cycle after rst deasserts? no -- InReady=1 immediately.
REQ-030 SHALL discard buffered entries on reset mid-operation; no write of discarded entries ever occurs.

Configuration
REQ-031 SHALL with WB_LOAD_EXT_EN defined: byte = InMemData byte InByteOff (offset 0 = bits 7:0), half = halfword InByteOff[1] (InByteOff[0] ignored), sign/zero-extended per InLoadType.
REQ-032 SHALL without WB_LOAD_EXT_EN: InLoadType and InByteOff ignored; loads pass InMemData unmodified.

Structure
REQ-033 SHALL place load-type encodings, state encodings and the entry record typedef in shared package mips_pkg.
REQ-034 SHALL implement the load extension as sub-module load_extend (combinational, also under WB_LOAD_EXT_EN).

Verification
REQ-035 SHALL cover: ALU write Dest=5 Data=0x1234 accepted edge N, WbHold=0 -> RegWrite=1, WriteRegister=5, WriteData=0x1234 in cycle after N.
REQ-036 SHALL cover: Dest=0, InRegWrite=1 -> entry retires, RegWrite stays 0, FwdValid 0.
REQ-037 SHALL cover: WbHold=1 for 3 cycles with 3 back-to-back valids -> InReady falls after 2 accepts, third held, all three written in order once WbHold drops.
REQ-038 SHALL cover (WB_LOAD_EXT_EN): InMemData=0x80FF7F01, byte signed offset 3 -> 0xFFFFFF80; byte unsigned offset 2 -> 0x000000FF; half signed offset 2 -> 0xFFFF80FF.
REQ-039 SHALL cover: rst asserted in state TWO -> immediately RegWrite=0, FwdValid=0, InReady=1; no retained entry written afterwards.
REQ-040 SHALL cover: continuous valids, WbHold=0 -> one write per cycle, InReady never low.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types for the writeback retire buffer: load-type encodings, buffer states
// and the buffered entry record.
package mips_pkg;

    // Entry record is sized for the widest configuration the buffer supports.
    localparam int ENTRY_DATA_W = 32;
    localparam int ENTRY_ADDR_W = 5;

    typedef enum logic [1:0] {
        LOAD_WORD   = 2'b00,
        LOAD_BYTE_S = 2'b01,
        LOAD_BYTE_U = 2'b10,
        LOAD_HALF_S = 2'b11
    } loadType_t;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } bufState_t;

    typedef struct packed {
        logic                    regWrite;
        logic [ENTRY_ADDR_W-1:0] dest;
        logic [ENTRY_DATA_W-1:0] data;
    } retireEntry_t;

endpackage

// File: rtl/load_extend.sv
// Combinational byte/halfword selection and sign/zero extension of a loaded word.
// Only built when WB_LOAD_EXT_EN is defined.
`ifdef WB_LOAD_EXT_EN
module load_extend
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] memData,
    input  logic [1:0]        loadType,
    input  logic [1:0]        byteOff,
    output logic [DATA_W-1:0] extData
);

    logic [7:0]  selByte;
    logic [15:0] selHalf;

    // Halfword choice looks only at the upper offset bit; misaligned halves are not supported.
    always_comb begin
        selByte = memData[7:0];
        case (byteOff)
            2'd0:    selByte = memData[7:0];
            2'd1:    selByte = memData[15:8];
            2'd2:    selByte = memData[23:16];
            default: selByte = memData[31:24];
        endcase
        selHalf = byteOff[1] ? memData[31:16] : memData[15:0];
    end

    always_comb begin
        extData = memData;
        case (loadType_t'(loadType))
            LOAD_BYTE_S: extData = {{(DATA_W-8){selByte[7]}}, selByte};
            LOAD_BYTE_U: extData = {{(DATA_W-8){1'b0}}, selByte};
            LOAD_HALF_S: extData = {{(DATA_W-16){selHalf[15]}}, selHalf};
            default:     extData = memData;
        endcase
    end

endmodule
`endif

// File: rtl/wb_retire_buffer.sv
// Two-entry in-order writeback buffer between MEM and the register file, with head forwarding.
// Define WB_LOAD_EXT_EN to enable sub-word load extension; otherwise loads pass through raw.
module wb_retire_buffer
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              InValid,
    output logic              InReady,
    input  logic              InRegWrite,
    input  logic [ADDR_W-1:0] InDest,
    input  logic              InMemToReg,
    input  logic [DATA_W-1:0] InAluResult,
    input  logic [DATA_W-1:0] InMemData,
    input  logic [1:0]        InLoadType,
    input  logic [1:0]        InByteOff,
    input  logic              WbHold,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData,
    output logic              FwdValid,
    output logic [ADDR_W-1:0] FwdReg,
    output logic [DATA_W-1:0] FwdData
);

    bufState_t    state, stateNext;
    retireEntry_t head, tail, newEntry;
    logic         accept, retire, notEmpty, headWrites;
    logic [DATA_W-1:0] loadData;

`ifdef WB_LOAD_EXT_EN
    load_extend #(.DATA_W(DATA_W)) uLoadExtend (
        .memData (InMemData),
        .loadType(InLoadType),
        .byteOff (InByteOff),
        .extData (loadData)
    );
`else
    logic unusedLoadCtl;
    assign loadData      = InMemData;
    assign unusedLoadCtl = ^{InLoadType, InByteOff};
`endif

    assign notEmpty = (state != EMPTY);
    assign InReady  = (state != TWO);
    assign accept   = InValid && InReady;
    assign retire   = notEmpty && !WbHold;

    // Data is formatted on the way in so the head can be forwarded without further muxing.
    always_comb begin
        newEntry                    = '0;
        newEntry.regWrite           = InRegWrite;
        newEntry.dest[ADDR_W-1:0]   = InDest;
        newEntry.data[DATA_W-1:0]   = InMemToReg ? loadData : InAluResult;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            EMPTY: if (accept) stateNext = ONE;
            ONE: begin
                if (accept && !retire)      stateNext = TWO;
                else if (!accept && retire) stateNext = EMPTY;
            end
            TWO:     if (retire) stateNext = ONE;
            default: stateNext = EMPTY;
        endcase
    end

    // Vacated slots are cleared so a drained buffer presents all-zero fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            case (state)
                EMPTY: if (accept) head <= newEntry;
                ONE: begin
                    if (retire)      head <= accept ? newEntry : '0;
                    else if (accept) tail <= newEntry;
                end
                TWO: begin
                    if (retire) begin
                        head <= tail;
                        tail <= '0;
                    end
                end
                default: begin
                    head <= '0;
                    tail <= '0;
                end
            endcase
        end
    end

    assign headWrites    = notEmpty && head.regWrite && (head.dest != '0);
    assign FwdValid      = headWrites;
    assign RegWrite      = headWrites && !WbHold;
    assign FwdReg        = notEmpty ? head.dest[ADDR_W-1:0] : '0;
    assign WriteRegister = notEmpty ? head.dest[ADDR_W-1:0] : '0;
    assign FwdData       = notEmpty ? head.data[DATA_W-1:0] : '0;
    assign WriteData     = notEmpty ? head.data[DATA_W-1:0] : '0;

endmodule
